// File: rtl/up_dn_counter_param.sv
// Bounded up/down counter with a programmable step, runtime limits and a saturate/wrap mode.
// Overflow and underflow pulses are registered and line up with the counter update.
module up_dn_counter_param #(
  parameter int unsigned     WIDTH     = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             load,
  input  logic [WIDTH-1:0] IN,
  input  logic             up,
  input  logic             down,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] lim_lo,
  input  logic [WIDTH-1:0] lim_hi,
  input  logic             wrap,
  output logic [WIDTH-1:0] counter,
  output logic             high,
  output logic             low,
  output logic             ovf,
  output logic             unf,
  output logic             err
);

  localparam int unsigned EXT_W = WIDTH + 1;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_DOWN = 2'd2,
    OP_UP   = 2'd3
  } op_e;

  op_e              op;
  logic [EXT_W-1:0] sum_ext;
  logic [EXT_W-1:0] diff_ext;
  logic             sum_over;
  logic             diff_under;
  logic [WIDTH-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;

  // Limit compares and the error flag follow the live limit inputs
  assign high = (counter >= lim_hi);
  assign low  = (counter <= lim_lo);
  assign err  = (lim_lo > lim_hi);

  // One extra bit keeps carry/borrow visible instead of wrapping modulo 2^WIDTH
  assign sum_ext    = EXT_W'(counter) + EXT_W'(step);
  assign diff_ext   = EXT_W'(counter) - EXT_W'(step);
  assign sum_over   = (sum_ext > EXT_W'(lim_hi));
  assign diff_under = diff_ext[WIDTH] | (diff_ext[WIDTH-1:0] < lim_lo);

  // Request arbitration: load beats down beats up; down masks up even when blocked
  always_comb begin
    op = OP_HOLD;
    if (EN) begin
      if (load) begin
        op = OP_LOAD;
      end else if (!err && (step != '0)) begin
        if (down) begin
          op = OP_DOWN;
        end else if (up) begin
          op = OP_UP;
        end
      end
    end
  end

  // Next count and pulse generation for the selected operation
  always_comb begin
    cnt_nxt = counter;
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    case (op)
      OP_LOAD: begin
        cnt_nxt = IN;
      end
      OP_DOWN: begin
        if (low || diff_under) begin
          if (wrap) begin
            cnt_nxt = lim_hi;
            unf_nxt = 1'b1;
          end else if (!low) begin
            cnt_nxt = lim_lo;
            unf_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = diff_ext[WIDTH-1:0];
        end
      end
      OP_UP: begin
        if (high || sum_over) begin
          if (wrap) begin
            cnt_nxt = lim_lo;
            ovf_nxt = 1'b1;
          end else if (!high) begin
            cnt_nxt = lim_hi;
            ovf_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = sum_ext[WIDTH-1:0];
        end
      end
      default: begin
        cnt_nxt = counter;
      end
    endcase
  end

  // State register; reset discards whatever operation was pending
  always_ff @(posedge CLK) begin
    if (RST) begin
      counter <= RESET_VAL;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      counter <= cnt_nxt;
      ovf     <= ovf_nxt;
      unf     <= unf_nxt;
    end
  end

endmodule

// File: doc/up_dn_counter_param.md
Name: up_dn_counter_param

Overview:
Parametrised successor of the 5-bit up/down counter with load and high/low flags. It adds generic width, a programmable step, runtime lower and upper limits, a saturate/wrap mode, registered overflow/underflow pulses, an enable and a synchronous reset. It serves as the general-purpose bounded counter for timers, level trackers and credit counters in the datapath.

Parameters:
WIDTH, 5, counter/data width in bits (>=2)
RESET_VAL, 0, counter value loaded by RST (WIDTH bits)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous reset, active-high
EN  input  1  clock enable; when 0, all state holds (RST still acts)
load  input  1  parallel load request
IN  input  WIDTH  parallel load value
up  input  1  count-up request
down  input  1  count-down request
step  input  WIDTH  increment/decrement magnitude, unsigned
lim_lo  input  WIDTH  lower limit, unsigned
lim_hi  input  WIDTH  upper limit, unsigned
wrap  input  1  0 = saturate at limits, 1 = wrap to opposite limit
counter  output  WIDTH  registered count
high  output  1  combinational: counter >= lim_hi
low  output  1  combinational: counter <= lim_lo
ovf  output  1  registered 1-cycle pulse: an up step crossed lim_hi
unf  output  1  registered 1-cycle pulse: a down step crossed lim_lo
err  output  1  combinational: lim_lo > lim_hi

Behaviour:
- Reset: RST=1 at edge -> counter=RESET_VAL, ovf=0, unf=0. RST overrides EN, load, up and down. Reset mid-count discards the pending operation.
- EN=0 and RST=0 -> counter holds; ovf=unf=0 on that edge.
- Priority when EN=1: load > down > up. When up and down are both high, up is ignored even if down is blocked (anti-flicker rule kept from previous generation).
- load: counter <= IN raw, with no clamping against the limits. ovf=unf=0. load is allowed even when err=1.
- Arithmetic: sum = counter + step and diff = counter - step, both computed at WIDTH+1 bits. No silent modulo-2^WIDTH wrap.
- err=1 and no load -> up/down ignored, counter holds, no pulses.
- up (effective), wrap=0:
  - high=1 -> hold, ovf=0.
  - sum > lim_hi -> counter <= lim_hi, ovf=1.
  - otherwise counter <= sum.
- up, wrap=1:
  - high=1 or sum > lim_hi -> counter <= lim_lo, ovf=1.
  - otherwise counter <= sum.
- down (effective), wrap=0:
  - low=1 -> hold, unf=0.
  - diff < lim_lo (including negative) -> counter <= lim_lo, unf=1.
  - otherwise counter <= diff.
- down, wrap=1:
  - low=1 or diff < lim_lo -> counter <= lim_hi, unf=1.
  - otherwise counter <= diff.
- step=0 -> up/down are no-ops. Counter holds, no pulses, in either mode.
- Counter loaded outside [lim_lo, lim_hi]: flags reflect the >=/<= compare. The next count resolves the value through the rules above (e.g. up in saturate mode while above lim_hi holds).
- Limits and wrap are sampled every cycle. Changing them mid-operation takes effect on the next edge, with no internal latching.
- Latency: one edge from request to counter update. ovf/unf are aligned with that same update and last exactly one cycle unless re-triggered.
- No request active -> counter holds, ovf=unf=0.

Test Plan:
1. Reset: counter=17, RST=1 with up=1 -> next edge counter=0, ovf=unf=0, low=1 (lim_lo=0, lim_hi=31).
2. Saturate up: wrap=0, lim 0..31, step=4, counter=29, up -> counter=31, ovf=1 for one cycle. Up again -> counter=31, ovf=0, high=1.
3. Wrap down: wrap=1, lim 3..20, step=2, counter=4, down -> counter=20, unf=1. Next down -> 18, unf=0.
4. Simultaneous up and down: wrap=0, lim 0..31, counter=0, up=down=1 -> counter stays 0, no pulses. Counter=10, step=3 -> counter=7.
5. Load priority and out of range: lim 0..20, load=1, IN=25, down=1 -> counter=25, high=1. Then down with step=1 -> 24. In saturate mode, up at 24 -> holds.
6. Error and enable: lim_lo=10, lim_hi=5, counter=7, up -> unchanged, err=1. load IN=9 -> counter=9. EN=0 with load IN=2 -> counter stays 9.
